// File: rtl/cpu_trace_buffer_if.sv
// Bus bundle for the 6502 instruction trace buffer: CPU capture taps,
// trigger/arm controls and the frozen-buffer readout port.
interface cpu_trace_buffer_if #(
  parameter int DEPTH = 256,
  parameter int CYC_W = 16
);
  localparam int PW    = $clog2(DEPTH);
  localparam int REC_W = 56 + CYC_W;

  logic             fetch;
  logic             stall;
  logic [15:0]      pc;
  logic [7:0]       a;
  logic [7:0]       x;
  logic [7:0]       y;
  logic [7:0]       sp;
  logic [7:0]       p;
  logic             arm;
  logic             mode;
  logic [15:0]      trig_pc;
  logic [PW:0]      post_cnt;
  logic             force_stop;
  logic             rd_en;
  logic             rd_valid;
  logic [REC_W-1:0] rd_data;
  logic [PW:0]      count;
  logic             wrapped;
  logic [1:0]       state_o;

  modport master (
    output fetch, stall, pc, a, x, y, sp, p,
    output arm, mode, trig_pc, post_cnt, force_stop, rd_en,
    input  rd_valid, rd_data, count, wrapped, state_o
  );

  modport slave (
    input  fetch, stall, pc, a, x, y, sp, p,
    input  arm, mode, trig_pc, post_cnt, force_stop, rd_en,
    output rd_valid, rd_data, count, wrapped, state_o
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// On-chip 6502 instruction trace recorder: circular capture around a PC
// trigger (pre- or post-trigger mode), then frozen oldest-first readout.
module cpu_trace_buffer #(
  parameter int DEPTH = 256,
  parameter int CYC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  cpu_trace_buffer_if.slave  bus
);
  localparam int PW    = $clog2(DEPTH);
  localparam int REC_W = 56 + CYC_W;
  localparam logic [PW:0]      DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]      LAST_C  = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0]      ONE_C   = (PW+1)'(1);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CYC_W-1:0] DLT_ONE = CYC_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    STOPPED   = 2'd3
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic [PW:0]      post_q;
  logic             wrapped_q;
  logic [CYC_W-1:0] delta;
  logic             rd_valid_q;
  logic [REC_W-1:0] rd_data_q;
  logic [REC_W-1:0] mem [DEPTH];

  logic cap;
  logic hit;
  logic full;
  logic we;
  logic rd_ok;

  assign cap  = bus.fetch & ~bus.stall;
  assign hit  = cap & (bus.pc == bus.trig_pc);
  assign full = (cnt == DEPTH_C);

  // Post mode records nothing before the trigger and never overwrites.
  always_comb begin
    we = 1'b0;
    case (state)
      ARMED:     we = mode_q ? hit : cap;
      TRIGGERED: we = mode_q ? (cap & ~full) : cap;
      default:   we = 1'b0;
    endcase
    if (bus.arm) we = 1'b0;
  end

  assign rd_ok = (state == STOPPED) & bus.rd_en & (cnt != '0) & ~bus.arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      post_q     <= '0;
      wrapped_q  <= 1'b0;
      delta      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;

      // Captured delta is the pre-load value, so the reload is 1, not 0.
      if (bus.arm | cap)
        delta <= DLT_ONE;
      else if (!bus.stall && delta != '1)
        delta <= delta + DLT_ONE;

      if (bus.arm) begin
        state     <= ARMED;
        mode_q    <= bus.mode;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt       <= '0;
        post_q    <= '0;
        wrapped_q <= 1'b0;
      end else begin
        if (we) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (full) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            wrapped_q <= 1'b1;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        if (rd_ok) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          cnt    <= cnt - ONE_C;
        end

        case (state)
          ARMED: begin
            if (hit && !mode_q) post_q <= bus.post_cnt;
            if (bus.force_stop)
              state <= STOPPED;
            else if (hit)
              state <= (!mode_q && bus.post_cnt == '0) ? STOPPED : TRIGGERED;
          end
          TRIGGERED: begin
            if (!mode_q) begin
              if (cap) post_q <= post_q - ONE_C;
              if (bus.force_stop || (cap && post_q == ONE_C)) state <= STOPPED;
            end else if (bus.force_stop || (we && cnt == LAST_C)) begin
              state <= STOPPED;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Record store: one write port, registered read for block-RAM mapping.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= {delta, bus.p, bus.sp, bus.y, bus.x, bus.a, bus.pc};
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data_q <= '0;
    else if (rd_ok)
      rd_data_q <= mem[rd_ptr];
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.count    = cnt;
  assign bus.wrapped  = wrapped_q;
  assign bus.state_o  = state;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: queue-based reference model
// compared every cycle, directed scenarios with literal expectations, random soak.
module tb_cpu_trace_buffer;
  localparam int DEPTH = 8;
  localparam int CYC_W = 16;
  localparam int PW    = 3;
  localparam int REC_W = 56 + CYC_W;
  localparam int DMAX  = (1 << CYC_W) - 1;

  typedef logic [REC_W-1:0] rec_t;
  typedef logic [PW:0]      cnt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_trace_buffer_if #(.DEPTH(DEPTH), .CYC_W(CYC_W)) bus ();
  cpu_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: oldest-first record queue plus trigger bookkeeping.
  rec_t q[$];
  int   m_state = 0;
  bit   m_mode = 1'b0;
  bit   m_wrapped = 1'b0;
  int   m_post = 0;
  int   m_delta = 0;
  bit   m_rdv = 1'b0;
  rec_t m_rdd = '0;

  function automatic void push(input rec_t r);
    if (q.size() == DEPTH) begin
      void'(q.pop_front());
      m_wrapped = 1'b1;
    end
    q.push_back(r);
  endfunction

  always @(posedge clk) begin
    bit   cap, hit;
    int   ns;
    rec_t rec;
    if (rst) begin
      q.delete();
      m_state = 0; m_mode = 1'b0; m_wrapped = 1'b0; m_post = 0;
      m_delta = 0; m_rdv = 1'b0; m_rdd = '0;
    end else begin
      cap = bus.fetch && !bus.stall;
      hit = cap && (bus.pc == bus.trig_pc);
      rec = {CYC_W'(m_delta), bus.p, bus.sp, bus.y, bus.x, bus.a, bus.pc};
      m_rdv = 1'b0;
      ns = m_state;
      if (bus.arm) begin
        ns = 1; q.delete(); m_wrapped = 1'b0; m_post = 0; m_mode = bus.mode;
      end else begin
        case (m_state)
          1: begin
            if (!m_mode) begin
              if (cap) push(rec);
              if (hit) begin
                m_post = int'(bus.post_cnt);
                ns = (m_post == 0) ? 3 : 2;
              end
            end else if (hit) begin
              push(rec);
              ns = 2;
            end
            if (bus.force_stop) ns = 3;
          end
          2: begin
            if (!m_mode) begin
              if (cap) begin
                push(rec);
                m_post--;
                if (m_post == 0) ns = 3;
              end
            end else if (cap && q.size() < DEPTH) begin
              push(rec);
              if (q.size() == DEPTH) ns = 3;
            end
            if (bus.force_stop) ns = 3;
          end
          3: if (bus.rd_en && q.size() > 0) begin
            m_rdd = q.pop_front();
            m_rdv = 1'b1;
          end
          default: ;
        endcase
      end
      m_state = ns;
      if (bus.arm || cap) m_delta = 1;
      else if (!bus.stall && m_delta < DMAX) m_delta++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state_o",  128'(bus.state_o),  128'(m_state));
      check("count",    128'(bus.count),    128'(q.size()));
      check("wrapped",  128'(bus.wrapped),  128'(m_wrapped));
      check("rd_valid", 128'(bus.rd_valid), 128'(m_rdv));
      check("rd_data",  128'(bus.rd_data),  128'(m_rdd));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.fetch = 1'b0; bus.stall = 1'b0; bus.arm = 1'b0;
    bus.force_stop = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_regs();
    bus.a = 8'($urandom); bus.x = 8'($urandom); bus.y = 8'($urandom);
    bus.sp = 8'($urandom); bus.p = 8'($urandom);
  endtask

  task automatic do_fetch(input logic [15:0] pcv);
    bus.fetch = 1'b1; bus.pc = pcv; rand_regs();
    step();
    bus.fetch = 1'b0;
  endtask

  task automatic do_arm(input bit m, input logic [15:0] tpc, input int pcnt);
    clear_inputs();
    bus.mode = m; bus.trig_pc = tpc; bus.post_cnt = cnt_t'(pcnt);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    bus.pc = '0; bus.trig_pc = '0; bus.mode = 1'b0; bus.post_cnt = '0;
    rand_regs();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // Reset / idle: fetches without arm record nothing.
    for (int i = 0; i < 20; i++) begin
      do_fetch(16'(16'h8000 + i));
      idle(1);
    end
    check("t1_count", 128'(bus.count), 128'(0));
    check("t1_state", 128'(bus.state_o), 128'(0));
    check("t1_rd_valid", 128'(bus.rd_valid), 128'(0));

    // Pre-trigger mode with wrap.
    do_arm(1'b0, 16'h8010, 2);
    for (int i = 0; i <= 16'h12; i++) begin
      idle(2);
      do_fetch(16'(16'h8000 + i));
    end
    idle(2);
    check("t2_state", 128'(bus.state_o), 128'(3));
    check("t2_wrapped", 128'(bus.wrapped), 128'(1));
    check("t2_count", 128'(bus.count), 128'(8));
    check("t2_model_count", 128'(q.size()), 128'(8));
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t2_rd_valid", 128'(bus.rd_valid), 128'(1));
      check("t2_rd_pc", 128'(bus.rd_data[15:0]), 128'(16'h800B + i));
      check("t2_rd_delta", 128'(bus.rd_data[REC_W-1:56]), 128'(3));
    end
    idle(1);
    check("t2_count_empty", 128'(bus.count), 128'(0));

    // Post-trigger mode: trigger at the 5th fetch, fill without wrap.
    do_arm(1'b1, 16'h0400, 0);
    for (int i = 0; i < 4; i++) begin do_fetch(16'(16'h0100 + i)); idle(1); end
    for (int i = 0; i < 12; i++) begin do_fetch(16'(16'h0400 + i)); idle(1); end
    check("t3_state", 128'(bus.state_o), 128'(3));
    check("t3_count", 128'(bus.count), 128'(8));
    check("t3_wrapped", 128'(bus.wrapped), 128'(0));
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_rd_pc", 128'(bus.rd_data[15:0]), 128'(16'h0400 + i));
    end
    step();
    check("t3_empty_rd_valid", 128'(bus.rd_valid), 128'(0));
    idle(1);

    // Delta saturation and stall freeze; force_stop keeps the same-cycle record.
    do_arm(1'b0, 16'hFFFF, 0);
    do_fetch(16'h3000);
    idle(70000);
    do_fetch(16'h3001);
    for (int i = 0; i < 13; i++) begin
      bus.stall = (i % 4 != 0) || (i > 9) ? 1'b1 : 1'b0;
      if (i == 0 || i == 4 || i == 8) bus.stall = 1'b0;
      step();
    end
    bus.stall = 1'b0; bus.force_stop = 1'b1;
    do_fetch(16'h3002);
    bus.force_stop = 1'b0;
    check("t4_state", 128'(bus.state_o), 128'(3));
    check("t4_count", 128'(bus.count), 128'(3));
    bus.rd_en = 1'b1;
    step();
    check("t4_delta_first", 128'(bus.rd_data[REC_W-1:56]), 128'(1));
    step();
    check("t4_delta_sat", 128'(bus.rd_data[REC_W-1:56]), 128'(16'hFFFF));
    step();
    check("t4_delta_stall", 128'(bus.rd_data[REC_W-1:56]), 128'(4));
    check("t4_forced_pc", 128'(bus.rd_data[15:0]), 128'(16'h3002));
    idle(1);

    // Trigger with post_cnt=0 stops with the trigger record last.
    do_arm(1'b0, 16'h1234, 0);
    do_fetch(16'h1000); idle(1);
    do_fetch(16'h1001); idle(1);
    do_fetch(16'h1234); idle(1);
    do_fetch(16'h1235); idle(1);
    check("t5_state", 128'(bus.state_o), 128'(3));
    check("t5_count", 128'(bus.count), 128'(3));
    check("t5_model_last", 128'(q[2][15:0]), 128'(16'h1234));
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    check("t5_rd_pc", 128'(bus.rd_data[15:0]), 128'(16'h1000));
    bus.arm = 1'b1; bus.rd_en = 1'b1; step();
    clear_inputs();
    check("t5_arm_rd_state", 128'(bus.state_o), 128'(1));
    check("t5_arm_rd_count", 128'(bus.count), 128'(0));
    check("t5_arm_rd_valid", 128'(bus.rd_valid), 128'(0));
    bus.force_stop = 1'b1; step(); bus.force_stop = 1'b0;
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    check("t5_empty_state", 128'(bus.state_o), 128'(3));
    check("t5_empty_rd_valid", 128'(bus.rd_valid), 128'(0));
    idle(1);

    // Randomized soak over a small PC space so triggers are frequent.
    for (int r = 0; r < 6; r++) begin
      do_arm(r[0], 16'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      for (int c = 0; c < 400; c++) begin
        bus.stall      = ($urandom_range(0, 3) == 0);
        bus.fetch      = ($urandom_range(0, 1) == 1);
        bus.pc         = 16'($urandom_range(0, 15));
        rand_regs();
        bus.force_stop = ($urandom_range(0, 199) == 0);
        bus.rd_en      = ($urandom_range(0, 2) == 0);
        bus.arm        = ($urandom_range(0, 299) == 0);
        step();
      end
      idle(2);
    end

    // Reset in the middle of readout.
    do_arm(1'b0, 16'h2009, 1);
    for (int i = 0; i < 11; i++) begin do_fetch(16'(16'h2000 + i)); idle(1); end
    check("t6_count_full", 128'(bus.count), 128'(8));
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.rd_en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_state", 128'(bus.state_o), 128'(0));
    check("t6_count", 128'(bus.count), 128'(0));
    check("t6_wrapped", 128'(bus.wrapped), 128'(0));
    check("t6_rd_valid", 128'(bus.rd_valid), 128'(0));
    check("t6_rd_data", 128'(bus.rd_data), 128'(0));
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
